// File: rtl/shared_reg_arbiter_pkg.sv
// Shared types and helpers for the shared-register arbiter.
// State encoding and a ceiling-log2 helper that never returns less than one bit.
package shared_reg_arbiter_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_OWN  = 1'b1
    } state_t;

    function automatic int clog2_min1(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/shared_reg_arbiter_if.sv
// Requester-side bundle of the shared-register arbiter: requests and data in,
// grant/ack/register contents out. master = requester logic, slave = arbiter.
interface shared_reg_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8
);
    import shared_reg_arbiter_pkg::*;

    localparam int IW = clog2_min1(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] wdata;
    logic [NREQ-1:0]       gnt;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [IW-1:0]         owner;
    logic                  busy;

    modport master (
        output req, wdata,
        input  gnt, ack, q, owner, busy
    );

    modport slave (
        input  req, wdata,
        output gnt, ack, q, owner, busy
    );

endinterface

// File: rtl/shared_reg_arbiter_rr_pick.sv
// Round-robin pick: first set request bit after the last owner, wrapping.
// Purely combinational; vld is low when no request is present.
module shared_reg_arbiter_rr_pick
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = clog2_min1(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic [IW-1:0]   winner,
    output logic            vld
);

    logic [NREQ-1:0] rot;

    // rot[0] is the requester right after the last owner, i.e. highest priority
    always_comb begin
        rot    = '0;
        winner = '0;
        for (int i = 0; i < NREQ; i++) begin
            rot[i] = req[(int'(last) + 1 + i) % NREQ];
        end
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (rot[i]) winner = IW'((int'(last) + 1 + i) % NREQ);
        end
    end

    assign vld = |req;

endmodule

// File: rtl/shared_reg_arbiter.sv
// Round-robin arbiter/write sequencer for one shared WIDTH-bit register.
// Grant and capture one edge after request; ownership held HOLD cycles, requests ignored meanwhile.
module shared_reg_arbiter
    import shared_reg_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int HOLD  = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    shared_reg_arbiter_if.slave bus
);

    localparam int IW = clog2_min1(NREQ);
    localparam int CW = clog2_min1(HOLD);

    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic [IW-1:0]    last, last_nxt;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic [IW-1:0]    owner_r, owner_nxt;
    logic [NREQ-1:0]  gnt_r, gnt_nxt;
    logic [NREQ-1:0]  ack_r, ack_nxt;
    logic             busy_r, busy_nxt;

    logic [IW-1:0]    winner;
    logic             win_vld;
    logic             arb;

    shared_reg_arbiter_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req    (bus.req),
        .last   (last),
        .winner (winner),
        .vld    (win_vld)
    );

    // The last cycle of an ownership is also an arbitration point, so grants run back to back
    assign arb = (state == ST_IDLE) || (cnt == '0);

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        last_nxt  = last;
        q_nxt     = q_r;
        owner_nxt = owner_r;
        gnt_nxt   = gnt_r;
        ack_nxt   = '0;
        busy_nxt  = busy_r;
        if (arb) begin
            if (win_vld) begin
                state_nxt       = ST_OWN;
                cnt_nxt         = CW'(HOLD - 1);
                last_nxt        = winner;
                owner_nxt       = winner;
                q_nxt           = bus.wdata[int'(winner) * WIDTH +: WIDTH];
                gnt_nxt         = '0;
                gnt_nxt[winner] = 1'b1;
                ack_nxt[winner] = 1'b1;
                busy_nxt        = 1'b1;
            end else begin
                state_nxt = ST_IDLE;
                gnt_nxt   = '0;
                busy_nxt  = 1'b0;
            end
        end else begin
            cnt_nxt = cnt - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            last    <= IW'(NREQ - 1);
            q_r     <= '0;
            owner_r <= '0;
            gnt_r   <= '0;
            ack_r   <= '0;
            busy_r  <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            last    <= last_nxt;
            q_r     <= q_nxt;
            owner_r <= owner_nxt;
            gnt_r   <= gnt_nxt;
            ack_r   <= ack_nxt;
            busy_r  <= busy_nxt;
        end
    end

    assign bus.gnt   = gnt_r;
    assign bus.ack   = ack_r;
    assign bus.q     = q_r;
    assign bus.owner = owner_r;
    assign bus.busy  = busy_r;

endmodule

// File: tb/tb_shared_reg_arbiter.sv
// Directed plus random stimulus for shared_reg_arbiter, checked every cycle
// against a cycle-count reference model of the arbitration rules.
module tb_shared_reg_arbiter;

    localparam int NREQ  = 4;
    localparam int WIDTH = 8;
    localparam int HOLD  = 2;

    logic clk;
    logic rst_n;

    shared_reg_arbiter_if #(.NREQ(NREQ), .WIDTH(WIDTH)) bus ();

    shared_reg_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH),
        .HOLD  (HOLD)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: m_left = ownership cycles still to run, 0 when idle
    logic [WIDTH-1:0] m_q;
    logic [NREQ-1:0]  m_gnt, m_ack;
    int               m_owner, m_last, m_left;
    logic             m_busy;

    task automatic model_reset();
        m_q = '0; m_gnt = '0; m_ack = '0; m_owner = 0; m_busy = 1'b0;
        m_last = NREQ - 1; m_left = 0;
    endtask

    task automatic model_edge(input logic [NREQ-1:0] r, input logic [NREQ*WIDTH-1:0] d);
        int w;
        if (m_left <= 1) begin
            if (r != '0) begin
                w = -1;
                for (int k = 1; k <= NREQ; k++)
                    if (w < 0 && r[(m_last + k) % NREQ]) w = (m_last + k) % NREQ;
                m_q = d[w*WIDTH +: WIDTH];
                m_owner = w; m_last = w;
                m_gnt = NREQ'(1) << w; m_ack = m_gnt;
                m_busy = 1'b1; m_left = HOLD;
            end else begin
                m_gnt = '0; m_ack = '0; m_busy = 1'b0; m_left = 0;
            end
        end else begin
            m_left--; m_ack = '0;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_all();
        chk("gnt", 32'(bus.gnt), 32'(m_gnt));
        chk("ack", 32'(bus.ack), 32'(m_ack));
        chk("q", 32'(bus.q), 32'(m_q));
        chk("owner", 32'(bus.owner), 32'(m_owner));
        chk("busy", 32'(bus.busy), 32'(m_busy));
    endtask

    // One clock edge: model consumes the inputs present at the edge, outputs checked 1 ns later
    task automatic cyc();
        @(posedge clk);
        model_edge(bus.req, bus.wdata);
        #1;
        check_all();
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req = '0;
        bus.wdata = '0;
        model_reset();
        #3;
        check_all();
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-ownership while requester 1 holds the grant
        bus.wdata = 32'h44332211;
        bus.req = 4'b1111;
        cyc(); chk("t1_first_gnt", 32'(bus.gnt), 32'h1);
        cyc();
        cyc(); chk("t1_gnt_before_rst", 32'(bus.gnt), 32'h2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        chk("t1_gnt_in_rst", 32'(bus.gnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(); chk("t1_gnt_after_rst", 32'(bus.gnt), 32'h1);
        chk("t1_q_after_rst", 32'(bus.q), 32'h11);

        // Single request from requester 2
        bus.req = '0;
        cyc(); cyc(); cyc();
        bus.wdata[2*WIDTH +: WIDTH] = 8'hA5;
        bus.req = 4'b0100;
        cyc(); chk("t2_ack", 32'(bus.ack), 32'h4);
        chk("t2_q", 32'(bus.q), 32'hA5);
        chk("t2_owner", 32'(bus.owner), 32'd2);
        bus.req = '0;
        cyc(); chk("t2_ack_pulse", 32'(bus.ack), 32'h0);
        chk("t2_gnt_held", 32'(bus.gnt), 32'h4);
        cyc(); chk("t2_busy_drop", 32'(bus.busy), 32'h0);

        // Round robin from a fresh pointer
        rst_n = 1'b0;
        model_reset();
        #2;
        rst_n = 1'b1;
        bus.wdata = 32'h44332211;
        bus.req = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            cyc();
            chk("t3_q", 32'(bus.q), 32'((g % 4 + 1) * 8'h11));
            chk("t3_ack", 32'(bus.ack), 32'(1 << (g % 4)));
            cyc();
            chk("t3_q_hold", 32'(bus.q), 32'((g % 4 + 1) * 8'h11));
        end

        // Wrap: requester 3 owns last, then 0 and 3 alternate
        bus.req = 4'b1000;
        cyc(); chk("t4_gnt3", 32'(bus.gnt), 32'h8);
        cyc();
        bus.req = 4'b1001;
        cyc(); chk("t4_gnt0", 32'(bus.gnt), 32'h1);
        cyc();
        cyc(); chk("t4_gnt3b", 32'(bus.gnt), 32'h8);
        cyc();
        cyc(); chk("t4_gnt0b", 32'(bus.gnt), 32'h1);

        // Request pulse that falls entirely inside a hold is lost
        bus.req = '0;
        cyc(); cyc();
        bus.req = 4'b0010;
        cyc(); chk("t5_gnt1", 32'(bus.gnt), 32'h2);
        bus.req = 4'b0100;
        cyc(); chk("t5_gnt_held", 32'(bus.gnt), 32'h2);
        bus.req = '0;
        cyc(); chk("t5_no_gnt2", 32'(bus.gnt), 32'h0);
        chk("t5_q_kept", 32'(bus.q), 32'h22);

        // Contention: slice 1 changes during requester 0's hold
        bus.wdata = 32'h44335A11;
        bus.req = 4'b0011;
        cyc(); chk("t6_gnt0", 32'(bus.gnt), 32'h1);
        bus.wdata[1*WIDTH +: WIDTH] = 8'h77;
        cyc(); chk("t6_q_stable", 32'(bus.q), 32'h11);
        bus.wdata[1*WIDTH +: WIDTH] = 8'h99;
        cyc(); chk("t6_q_capture", 32'(bus.q), 32'h99);
        chk("t6_owner", 32'(bus.owner), 32'd1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            bus.req = ($urandom_range(0, 3) == 0) ? '0 : NREQ'($urandom);
            bus.wdata = $urandom;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
